// File: rtl/cp0_ctrl_pkg.sv
// Shared CP0 definitions: register numbers, exception codes, write masks, reset values.
package cp0_ctrl_pkg;
  localparam logic [4:0] CP0_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_COUNT    = 5'd9;
  localparam logic [4:0] CP0_COMPARE  = 5'd11;
  localparam logic [4:0] CP0_STATUS   = 5'd12;
  localparam logic [4:0] CP0_CAUSE    = 5'd13;
  localparam logic [4:0] CP0_EPC      = 5'd14;

  localparam logic [4:0] EXC_INT  = 5'h00;
  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;
  localparam logic [4:0] EXC_SYS  = 5'h08;
  localparam logic [4:0] EXC_BP   = 5'h09;
  localparam logic [4:0] EXC_RI   = 5'h0A;
  localparam logic [4:0] EXC_OV   = 5'h0C;
  localparam logic [4:0] EXC_NONE = 5'h10;
  localparam logic [4:0] EXC_ERET = 5'h11;

  localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;
  localparam logic [31:0] CAUSE_WMASK  = 32'h0000_0300;
  localparam logic [31:0] STATUS_RST   = 32'h1000_0000;

  typedef struct packed {
    logic [4:0]  code;
    logic [31:0] pc;
    logic        in_delay;
    logic [31:0] badvaddr;
  } exc_req_t;

  function automatic logic is_exc(input logic [4:0] code);
    return (code != EXC_NONE) && (code != EXC_ERET);
  endfunction
endpackage

// File: rtl/cp0_timer.sv
// Prescaled Count/Compare timer with sticky timer-interrupt flag.
module cp0_timer #(
  parameter int COUNT_DIV_LOG2 = 1
) (
  input  logic        cpu_clk_50M,
  input  logic        cpu_rst_n,
  input  logic        count_we,
  input  logic        compare_we,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        ti
);
  localparam int PW = (COUNT_DIV_LOG2 > 0) ? COUNT_DIV_LOG2 : 1;

  logic [PW-1:0] pre;
  logic          tick;

  assign tick = (COUNT_DIV_LOG2 == 0) || (pre == {PW{1'b1}});

  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      pre     <= '0;
      count   <= '0;
      compare <= '0;
      ti      <= 1'b0;
    end else begin
      // a Count write restarts the prescaler so the new value holds a full period
      if (count_we) begin
        count <= wdata;
        pre   <= '0;
      end else begin
        pre <= pre + 1'b1;
        if (tick) count <= count + 32'd1;
      end
      if (compare_we) begin
        compare <= wdata;
        ti      <= 1'b0;
      end else if (count == compare) begin
        ti <= 1'b1;
      end
    end
  end
endmodule

// File: rtl/cp0_ctrl.sv
// MiniMIPS32 CP0 controller: exception entry/return, interrupts, MTC0/MFC0.
// Timer (Count/Compare/TI) is present only when CP0_TIMER_EN is defined.
module cp0_ctrl
  import cp0_ctrl_pkg::*;
#(
  parameter int          HW_INT_NUM     = 6,
  parameter int          COUNT_DIV_LOG2 = 1,
  parameter logic [31:0] EXC_VECTOR     = 32'hBFC0_0380,
  parameter logic [31:0] INT_VECTOR     = 32'hBFC0_0380
) (
  input  logic                  cpu_clk_50M,
  input  logic                  cpu_rst_n,
  input  logic                  we,
  input  logic [4:0]            waddr,
  input  logic [31:0]           wdata,
  input  logic                  re,
  input  logic [4:0]            raddr,
  output logic [31:0]           rdata,
  input  logic [HW_INT_NUM-1:0] int_i,
  input  logic [4:0]            exccode_i,
  input  logic [31:0]           pc_i,
  input  logic                  in_delay_i,
  input  logic [31:0]           badvaddr_i,
  input  logic                  stall_i,
  output logic                  flush,
  output logic                  flush_im,
  output logic [31:0]           excaddr,
  output logic [31:0]           status_o,
  output logic [31:0]           cause_o,
  output logic                  int_req_o
);
  if (HW_INT_NUM < 1 || HW_INT_NUM > 6 || COUNT_DIV_LOG2 < 0 || COUNT_DIV_LOG2 > 4) begin : g_bad_param
    $error("cp0_ctrl: parameter out of range");
  end

  exc_req_t    req;
  logic        exc, eret, wr_ok;
  logic [31:0] status, epc, badvaddr, count, compare;
  logic        bd, ti;
  logic [4:0]  exccode;
  logic [1:0]  ip_sw;
  logic [5:0]  ip_hw, int_pad;
  logic [7:0]  ip;

  assign req   = '{code: exccode_i, pc: pc_i, in_delay: in_delay_i, badvaddr: badvaddr_i};
  assign exc   = is_exc(req.code);
  assign eret  = (req.code == EXC_ERET);
  assign flush = (req.code != EXC_NONE);
  assign wr_ok = we & ~flush;

`ifdef CP0_TIMER_EN
  cp0_timer #(.COUNT_DIV_LOG2(COUNT_DIV_LOG2)) u_timer (
    .cpu_clk_50M(cpu_clk_50M),
    .cpu_rst_n  (cpu_rst_n),
    .count_we   (wr_ok && waddr == CP0_COUNT),
    .compare_we (wr_ok && waddr == CP0_COMPARE),
    .wdata      (wdata),
    .count      (count),
    .compare    (compare),
    .ti         (ti)
  );
`else
  assign count   = '0;
  assign compare = '0;
  assign ti      = 1'b0;
`endif

  always_comb begin
    int_pad = '0;
    int_pad[HW_INT_NUM-1:0] = int_i;
  end

  assign ip       = {ti | ip_hw[5], ip_hw[4:0], ip_sw};
  assign status_o = status;
  assign cause_o  = {bd, ti, 14'b0, ip, 1'b0, exccode, 2'b0};

  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      status    <= STATUS_RST;
      epc       <= '0;
      badvaddr  <= '0;
      bd        <= 1'b0;
      exccode   <= '0;
      ip_sw     <= '0;
      ip_hw     <= '0;
      int_req_o <= 1'b0;
      flush_im  <= 1'b0;
    end else begin
      ip_hw     <= int_pad;
      int_req_o <= (|(ip & status[15:8])) & status[0] & ~status[1];
      if (!stall_i) flush_im <= flush;
      if (exc) begin
        // nested exceptions keep the original return point
        if (!status[1]) begin
          bd  <= req.in_delay;
          epc <= req.in_delay ? req.pc - 32'd4 : req.pc;
        end
        status[1] <= 1'b1;
        exccode   <= req.code;
        if (req.code == EXC_ADEL || req.code == EXC_ADES) badvaddr <= req.badvaddr;
      end else if (eret) begin
        status[1] <= 1'b0;
      end else if (wr_ok) begin
        // BadVAddr is hardware-written only
        case (waddr)
          CP0_STATUS: status <= (status & ~STATUS_WMASK) | (wdata & STATUS_WMASK);
          CP0_CAUSE:  ip_sw  <= wdata[9:8];
          CP0_EPC:    epc    <= wdata;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    excaddr = '0;
    if (req.code == EXC_INT)  excaddr = INT_VECTOR;
    else if (eret)            excaddr = (we && waddr == CP0_EPC) ? wdata : epc;
    else if (flush)           excaddr = EXC_VECTOR;
  end

  always_comb begin
    rdata = '0;
    if (re) begin
      case (raddr)
        CP0_BADVADDR: rdata = badvaddr;
        CP0_COUNT:    rdata = count;
        CP0_COMPARE:  rdata = compare;
        CP0_STATUS:   rdata = status;
        CP0_CAUSE:    rdata = cause_o;
        CP0_EPC:      rdata = epc;
        default:      rdata = '0;
      endcase
    end
  end
endmodule

// File: tb/tb_cp0_ctrl.sv
// Self-checking bench for cp0_ctrl: directed scenarios plus random traffic vs a cycle model.
module tb_cp0_ctrl;
  import cp0_ctrl_pkg::*;

  localparam int          HW  = 6;
  localparam int          DIV = 1;
  localparam logic [31:0] EV  = 32'hBFC0_0380;
  localparam logic [31:0] IV  = 32'hBFC0_0400;

  logic          clk, rst_n, we, re, in_delay_i, stall_i;
  logic [4:0]    waddr, raddr, exccode_i;
  logic [31:0]   wdata, rdata, pc_i, badvaddr_i, excaddr, status_o, cause_o;
  logic [HW-1:0] int_i;
  logic          flush, flush_im, int_req_o;

  cp0_ctrl #(.HW_INT_NUM(HW), .COUNT_DIV_LOG2(DIV), .EXC_VECTOR(EV), .INT_VECTOR(IV)) dut (
    .cpu_clk_50M(clk), .cpu_rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .re(re), .raddr(raddr), .rdata(rdata), .int_i(int_i), .exccode_i(exccode_i),
    .pc_i(pc_i), .in_delay_i(in_delay_i), .badvaddr_i(badvaddr_i), .stall_i(stall_i),
    .flush(flush), .flush_im(flush_im), .excaddr(excaddr), .status_o(status_o),
    .cause_o(cause_o), .int_req_o(int_req_o)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // architectural model
  logic [31:0] m_status, m_epc, m_bva, m_base, m_compare;
  logic        m_bd, m_ti, m_int_req, m_flush_im;
  logic [4:0]  m_exccode;
  logic [1:0]  m_ip_sw;
  logic [5:0]  m_hw;
  int unsigned m_cyc;

  task automatic m_reset();
    m_status = 32'h1000_0000; m_epc = 0; m_bva = 0; m_base = 0; m_compare = 0;
    m_bd = 0; m_ti = 0; m_int_req = 0; m_flush_im = 0; m_exccode = 0; m_ip_sw = 0;
    m_hw = 0; m_cyc = 0;
  endtask

  function automatic logic [31:0] m_count();
`ifdef CP0_TIMER_EN
    return m_base + 32'(m_cyc >> DIV);
`else
    return 32'd0;
`endif
  endfunction

  function automatic logic [31:0] m_cause();
    logic [7:0] ip;
    ip = {m_ti | m_hw[5], m_hw[4:0], m_ip_sw};
    return {m_bd, m_ti, 14'b0, ip, 1'b0, m_exccode, 2'b0};
  endfunction

  function automatic logic [31:0] m_rdata();
    if (!re) return 32'd0;
    case (raddr)
      5'd8:  return m_bva;
      5'd9:  return m_count();
      5'd11: return m_compare;
      5'd12: return m_status;
      5'd13: return m_cause();
      5'd14: return m_epc;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] m_excaddr();
    if (exccode_i == EXC_NONE) return 32'd0;
    if (exccode_i == EXC_INT)  return IV;
    if (exccode_i == EXC_ERET) return (we && waddr == 5'd14) ? wdata : m_epc;
    return EV;
  endfunction

  task automatic check_all();
    chk("status_o", status_o, m_status);
    chk("cause_o", cause_o, m_cause());
    chk("rdata", rdata, m_rdata());
    chk("flush", flush, exccode_i != EXC_NONE);
    chk("excaddr", excaddr, m_excaddr());
    chk("int_req_o", int_req_o, m_int_req);
    chk("flush_im", flush_im, m_flush_im);
  endtask

  // check current outputs, then advance model and DUT by one clock
  task automatic step();
    logic [31:0] n_status, n_epc, n_bva, n_base, n_compare, cur;
    logic        n_bd, n_ti, is_x, wr;
    logic [4:0]  n_exc;
    logic [1:0]  n_sw;
    int unsigned n_cyc;
    logic [7:0]  ip;
    #2;
    check_all();
    n_status = m_status; n_epc = m_epc; n_bva = m_bva; n_base = m_base;
    n_compare = m_compare; n_bd = m_bd; n_ti = m_ti; n_exc = m_exccode; n_sw = m_ip_sw;
    n_cyc = m_cyc;
    is_x = exccode_i != EXC_NONE && exccode_i != EXC_ERET;
    wr   = we && exccode_i == EXC_NONE;
    if (is_x) begin
      if (!m_status[1]) begin
        n_bd  = in_delay_i;
        n_epc = in_delay_i ? pc_i - 4 : pc_i;
      end
      n_status[1] = 1'b1;
      n_exc = exccode_i;
      if (exccode_i == EXC_ADEL || exccode_i == EXC_ADES) n_bva = badvaddr_i;
    end else if (exccode_i == EXC_ERET) begin
      n_status[1] = 1'b0;
    end else if (wr) begin
      if (waddr == 5'd12) n_status = (m_status & ~32'h0000_FF03) | (wdata & 32'h0000_FF03);
      if (waddr == 5'd13) n_sw = wdata[9:8];
      if (waddr == 5'd14) n_epc = wdata;
    end
`ifdef CP0_TIMER_EN
    cur = m_count();
    if (wr && waddr == 5'd11) begin n_compare = wdata; n_ti = 1'b0; end
    else if (cur == m_compare) n_ti = 1'b1;
    if (wr && waddr == 5'd9) begin n_base = wdata; n_cyc = 0; end
    else n_cyc = m_cyc + 1;
`else
    cur = 32'd0;
`endif
    ip = m_cause() >> 8;
    @(posedge clk);
    m_int_req = (|(ip & m_status[15:8])) && m_status[0] && !m_status[1];
    if (!stall_i) m_flush_im = exccode_i != EXC_NONE;
    m_hw = int_i;
    m_status = n_status; m_epc = n_epc; m_bva = n_bva; m_base = n_base;
    m_compare = n_compare; m_bd = n_bd; m_ti = n_ti; m_exccode = n_exc; m_ip_sw = n_sw;
    m_cyc = n_cyc;
    #1;
  endtask

  task automatic idle();
    we = 0; waddr = 0; wdata = 0; re = 0; raddr = 0; exccode_i = EXC_NONE;
    pc_i = 0; in_delay_i = 0; badvaddr_i = 0; stall_i = 0;
  endtask

  task automatic wr_reg(input logic [4:0] a, input logic [31:0] d);
    idle(); we = 1; waddr = a; wdata = d; step(); idle();
  endtask

  task automatic mid_reset();
    idle();
    rst_n = 0;
    #1;
    chk("rst_status", status_o, 32'h1000_0000);
    chk("rst_cause", cause_o, 32'd0);
    chk("rst_int_req", int_req_o, 1'b0);
    chk("rst_flush_im", flush_im, 1'b0);
    chk("rst_excaddr", excaddr, 32'd0);
    re = 1; raddr = 5'd9; #1;
    chk("rst_count", rdata, 32'd0);
    re = 0;
    m_reset();
    @(posedge clk); #1;
    rst_n = 1;
  endtask

  logic [4:0] addr_tab [7] = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd0};
  logic [4:0] exc_tab  [9] = '{EXC_INT, EXC_ADEL, EXC_ADES, EXC_SYS, EXC_BP, EXC_RI, EXC_OV, EXC_ERET, 5'h1F};

  function automatic logic [4:0] pick_addr();
    int k;
    k = $urandom_range(0, 6);
    return (k == 6) ? 5'($urandom) : addr_tab[k];
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 0; int_i = '0; idle(); m_reset();
    repeat (2) @(posedge clk);
    #1; rst_n = 1;
    chk("init_status", status_o, 32'h1000_0000);
    chk("init_cause", cause_o, 32'd0);

    wr_reg(5'd12, 32'hFFFF_FFFF);
    chk("status_mask", status_o, 32'h1000_FF03);

    int_i = 6'b000001;
    wr_reg(5'd12, 32'h1000_0401);
    step();
    chk("int_req_rise", int_req_o, 1'b1);

    exccode_i = EXC_INT; pc_i = 32'h8000_0100; in_delay_i = 1; #1;
    chk("int_flush", flush, 1'b1);
    chk("int_vector", excaddr, IV);
    step(); idle();
    re = 1; raddr = 5'd14; #1;
    chk("int_epc", rdata, 32'h8000_00FC);
    chk("int_bd", cause_o[31], 1'b1);
    chk("int_exl", status_o[1], 1'b1);
    step();
    chk("int_req_fall", int_req_o, 1'b0);

    idle(); exccode_i = EXC_ADEL; pc_i = 32'h8000_0200; badvaddr_i = 32'h1234_5679; #1;
    chk("adel_vector", excaddr, EV);
    step(); idle();
    re = 1; raddr = 5'd14; #1;
    chk("adel_epc", rdata, 32'h8000_00FC);
    raddr = 5'd8; #1;
    chk("adel_bva", rdata, 32'h1234_5679);
    chk("adel_code", cause_o[6:2], 5'h04);
    step();

    idle(); exccode_i = EXC_ERET; we = 1; waddr = 5'd14; wdata = 32'h8000_2000; #1;
    chk("eret_fwd", excaddr, 32'h8000_2000);
    step(); idle();
    re = 1; raddr = 5'd14; #1;
    chk("eret_exl", status_o[1], 1'b0);
    chk("eret_epc", rdata, 32'h8000_00FC);
    step();
    int_i = '0;

`ifdef CP0_TIMER_EN
    wr_reg(5'd9, 32'd100);
    wr_reg(5'd11, 32'd3);
    wr_reg(5'd9, 32'd0);
    repeat (6) step();
    chk("ti_early", cause_o[30], 1'b0);
    step();
    chk("ti_set", cause_o[30], 1'b1);
    repeat (3) step();
    chk("ti_sticky", cause_o[30], 1'b1);
    wr_reg(5'd11, 32'd50);
    chk("ti_clear", cause_o[30], 1'b0);
    wr_reg(5'd9, 32'd5);
    re = 1; raddr = 5'd9; #1;
    chk("count5", rdata, 32'd5);
`else
    wr_reg(5'd9, 32'd5);
    re = 1; raddr = 5'd9; #1;
    chk("count_off", rdata, 32'd0);
    step();
`endif
    mid_reset();

    for (int i = 0; i < 1500; i++) begin
      we = ($urandom_range(0, 3) == 0);
      waddr = pick_addr();
      wdata = (waddr == 5'd9 || waddr == 5'd11) ? 32'($urandom_range(0, 15)) : $urandom;
      re = $urandom_range(0, 1);
      raddr = pick_addr();
      exccode_i = ($urandom_range(0, 9) < 7) ? EXC_NONE : exc_tab[$urandom_range(0, 8)];
      pc_i = $urandom & 32'hFFFF_FFFC;
      in_delay_i = $urandom_range(0, 1);
      badvaddr_i = $urandom;
      stall_i = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 7) == 0) int_i = HW'($urandom);
      step();
      if (i == 700) mid_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
